mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle MIPS control FSM; successor to the single-cycle decoder.
//  Steps FETCH->DECODE->EXEC->MEM->WB per instruction. Drives datapath enables from state plus latched opcode/funct.
//  Handshakes with a shared variable-latency memory (mem_req/mem_ready) and counts retired instructions.
// PARAMETERS
//  ALUOP_W  4   width of alu_op (>=4; encodings from mc_pkg, zero-extended)
//  CNT_W    32  width of retired-instruction counter
//  EXC_VEC  32'h0000_0180  exception vector, reported on exc_vec (MC_EXC_EN only)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  opcode       in   6        IR[31:26]; valid from DECODE onward
//  funct        in   6        IR[5:0]
//  mem_ready    in   1        memory completes current request this cycle
//  pc_write     out  1        unconditional PC load
//  pc_write_cond out 1        PC load if branch condition true
//  bne_sel      out  1        1: branch on !zero (bne); 0: on zero (beq)
//  pc_src       out  2        0 ALU(pc+4), 1 branch target reg, 2 jump target, 3 rs(jr)/exc_vec
//  ir_write     out  1        latch instruction register
//  iord         out  1        memory address: 0 PC, 1 ALU result
//  mem_req      out  1        memory request, held until mem_ready
//  mem_we       out  1        write qualifier for mem_req
//  reg_write    out  1        register-file write
//  reg_dst      out  2        0 rt, 1 rd, 2 r31
//  mem_to_reg   out  1        writeback source is memory data
//  alu_src_a    out  1        0 PC, 1 rs
//  alu_src_b    out  2        0 rt, 1 const 4, 2 imm, 3 imm<<2
//  zero_ext     out  1        immediate zero-extended (andi/ori/xori)
//  alu_op       out  ALUOP_W  ALU operation
//  instret      out  CNT_W    retired-instruction count
//  halt         out  1        sticky; FSM stopped
//  state_o      out  4        current state, debug
// BEHAVIOUR
//  States: FETCH, DECODE, EX_R, EX_I, MADDR, MRD, MWR, WB_ALU, WB_MEM, BR, JMP, EXC, HALT.
//  rst (dominates every input): state<=FETCH, instret<=0, halt<=0. All outputs 0 while rst high.
//  Outputs are Moore, combinational from state and opcode/funct; no output depends on mem_ready except advancing.
//  FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, ADD. Stay while !mem_ready.
//    On mem_ready, same cycle: ir_write=1, pc_write=1, pc_src=0 -> DECODE.
//  DECODE: alu computes PC+imm<<2 (alu_src_b=3, ADD) into target reg. Then dispatch:
//    R-type->EX_R (jr: JMP, syscall: HALT); lw/sw->MADDR; beq/bne->BR; j/jal->JMP;
//    addi/addiu/slti/andi/ori/xori->EX_I; other opcodes->FETCH as NOP (retired).
//  EX_R: alu_src_a=1, alu_src_b=0, alu_op from funct; shifts sll/srl/sra -> WB_ALU.
//  EX_I: alu_src_b=2, zero_ext per opcode -> WB_ALU. WB_ALU: reg_write, reg_dst=1 (R) / 0 (I) -> FETCH.
//  MADDR: alu_src_a=1, alu_src_b=2, ADD -> MRD (lw) / MWR (sw).
//  MRD: mem_req, iord=1, hold until mem_ready -> WB_MEM. WB_MEM: reg_write, mem_to_reg, reg_dst=0 -> FETCH.
//  MWR: mem_req, mem_we, iord=1, hold until mem_ready -> FETCH.
//  BR: SUB rs,rt; pc_write_cond=1, pc_src=1, bne_sel=bne -> FETCH.
//  JMP: pc_write; pc_src=2 (j/jal) or 3 (jr). jal also reg_write, reg_dst=2 -> FETCH.
//  HALT: all enables 0, halt=1, held until rst.
//  Latency, zero-wait memory: R/I 4 cycles, lw 5, sw 4, br/j 3. Each wait cycle adds 1.
//  instret += 1 on every transition into FETCH from a non-reset state; wraps 2^CNT_W-1 -> 0.
//  mem_req never deasserts before mem_ready. mem_ready outside FETCH/MRD/MWR is ignored.
// CONFIGURATION
//  MC_EXC_EN defined: unknown opcode/funct or syscall -> EXC instead of NOP/HALT.
//    EXC (1 cycle): epc_write=1, cause_write=1, cause_code (5b: 10 RI, 8 Sys), pc_write, pc_src=3 -> FETCH.
//    Adds ports epc_write, cause_write, cause_code[4:0], exc_vec[31:0]=EXC_VEC. Excepting instr not counted.
//  MC_EXC_EN undefined: ports absent; unknown -> NOP; syscall -> HALT.
// STRUCTURE
//  mc_pkg: opcode/funct localparams, state enum (4b), ALU op codes (ADD,SUB,AND,OR,XOR,NOR,SLT,SLL,SRL,SRA), cause codes.
//  One sub-module: mc_alu_dec (pure combinational opcode/funct/state -> alu_op, zero_ext).
//  FSM next-state, output decode and counter stay in this file.
// TESTING
//  Reset mid-MRD with mem_ready=0 -> next cycle state_o=FETCH, mem_req=0, instret=0.
//  add, zero-wait -> FETCH,DECODE,EX_R,WB_ALU, reg_write only in WB_ALU with reg_dst=1; instret 0->1.
//  lw, mem_ready low 3 cycles in MRD -> mem_req,iord held 4 cycles, total 8 cycles, one WB_MEM pulse.
//  bne then jal -> BR: pc_write_cond=1, bne_sel=1; JMP: reg_write, reg_dst=2, pc_src=2; instret +2.
//  Preset instret to 2^CNT_W-1 via CNT_W=4 with 15 NOPs, one more -> instret=0.
//  opcode 6'b111111: without MC_EXC_EN retires as NOP; with it EXC, cause_code=10, pc_src=3, instret unchanged.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, functs, ALU op codes, FSM state encoding and exception causes for the multi-cycle MIPS control
package mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08, FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9;
  localparam logic [4:0] CAUSE_RI = 5'd10, CAUSE_SYS = 5'd8;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_MADDR, S_MRD, S_MWR,
    S_WB_ALU, S_WB_MEM, S_BR, S_JMP, S_EXC, S_HALT
  } state_t;
  function automatic logic r_known(input logic [5:0] f);
    return f inside {FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                     FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT};
  endfunction
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU operation and immediate-extension decode from state, opcode and funct
//   state    in  current FSM state
//   opcode   in  IR[31:26]
//   funct    in  IR[5:0]
//   alu_op   out ALU operation (ADD outside EX_R/EX_I/BR)
//   zero_ext out immediate is zero-extended (andi/ori/xori in EX_I)
module mc_alu_dec
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       zero_ext
);
  always_comb begin
    alu_op = ALU_ADD;
    zero_ext = 1'b0;
    if (state == S_BR) alu_op = ALU_SUB;
    else if (state == S_EX_R)
      case (funct)
        FN_SUB, FN_SUBU: alu_op = ALU_SUB;
        FN_AND:          alu_op = ALU_AND;
        FN_OR:           alu_op = ALU_OR;
        FN_XOR:          alu_op = ALU_XOR;
        FN_NOR:          alu_op = ALU_NOR;
        FN_SLT:          alu_op = ALU_SLT;
        FN_SLL:          alu_op = ALU_SLL;
        FN_SRL:          alu_op = ALU_SRL;
        FN_SRA:          alu_op = ALU_SRA;
        default:         alu_op = ALU_ADD;
      endcase
    else if (state == S_EX_I) begin
      case (opcode)
        OP_SLTI: alu_op = ALU_SLT;
        OP_ANDI: alu_op = ALU_AND;
        OP_ORI:  alu_op = ALU_OR;
        OP_XORI: alu_op = ALU_XOR;
        default: alu_op = ALU_ADD;
      endcase
      zero_ext = opcode inside {OP_ANDI, OP_ORI, OP_XORI};
    end
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control FSM with memory handshake and retired-instruction counter
//   Optional feature macro: MC_EXC_EN (exception state plus epc_write/cause_write/cause_code/exc_vec ports)
//   clk, rst                 clock, synchronous active-high reset
//   opcode, funct, mem_ready instruction fields and memory completion
//   pc_write, pc_write_cond, bne_sel, pc_src, ir_write, iord, mem_req, mem_we,
//   reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_op  datapath controls
//   instret, halt, state_o   retired count, sticky halt, debug state
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int CNT_W = 32
`ifdef MC_EXC_EN
  , parameter logic [31:0] EXC_VEC = 32'h0000_0180
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               bne_sel,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_req,
  output logic               mem_we,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               zero_ext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [CNT_W-1:0]   instret,
  output logic               halt,
  output logic [3:0]         state_o
`ifdef MC_EXC_EN
  , output logic             epc_write,
  output logic               cause_write,
  output logic [4:0]         cause_code,
  output logic [31:0]        exc_vec
`endif
);
`ifdef MC_EXC_EN
  localparam state_t S_SYS = S_EXC, S_BAD = S_EXC;
`else
  localparam state_t S_SYS = S_HALT, S_BAD = S_FETCH;
`endif
  state_t state, next, dispatch;
  logic [CNT_W-1:0] cnt;
  logic [3:0] dec_op;
  logic dec_zx;
  mc_alu_dec u_alu_dec (.state(state), .opcode(opcode), .funct(funct), .alu_op(dec_op), .zero_ext(dec_zx));
  always_comb begin
    dispatch = S_BAD;
    case (opcode)
      OP_RTYPE:       dispatch = funct == FN_JR ? S_JMP : funct == FN_SYSCALL ? S_SYS : r_known(funct) ? S_EX_R : S_BAD;
      OP_LW, OP_SW:   dispatch = S_MADDR;
      OP_BEQ, OP_BNE: dispatch = S_BR;
      OP_J, OP_JAL:   dispatch = S_JMP;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: dispatch = S_EX_I;
      default:        dispatch = S_BAD;
    endcase
  end
  always_comb begin
    next = state;
    case (state)
      S_FETCH:                                  next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:                                 next = dispatch;
      S_EX_R, S_EX_I:                           next = S_WB_ALU;
      S_MADDR:                                  next = opcode == OP_LW ? S_MRD : S_MWR;
      S_MRD:                                    next = mem_ready ? S_WB_MEM : S_MRD;
      S_MWR:                                    next = mem_ready ? S_FETCH : S_MWR;
      S_WB_ALU, S_WB_MEM, S_BR, S_JMP, S_EXC:   next = S_FETCH;
      default:                                  next = S_HALT;
    endcase
  end
  // An excepting instruction returns to FETCH without retiring; FETCH stalls are not transitions.
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_FETCH;
      cnt <= '0;
    end else begin
      state <= next;
      if (state != S_FETCH && state != S_EXC && next == S_FETCH) cnt <= cnt + CNT_W'(1);
    end
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    bne_sel = 1'b0;
    pc_src = 2'd0;
    ir_write = 1'b0;
    iord = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    reg_write = 1'b0;
    reg_dst = 2'd0;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    if (!rst)
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alu_src_b = 2'd1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: alu_src_b = 2'd3;
        S_EX_R: alu_src_a = 1'b1;
        S_EX_I, S_MADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          reg_dst = opcode == OP_RTYPE ? 2'd1 : 2'd0;
        end
        S_MRD: begin
          mem_req = 1'b1;
          iord = 1'b1;
        end
        S_MWR: begin
          mem_req = 1'b1;
          mem_we = 1'b1;
          iord = 1'b1;
        end
        S_WB_MEM: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BR: begin
          alu_src_a = 1'b1;
          pc_write_cond = 1'b1;
          pc_src = 2'd1;
          bne_sel = opcode == OP_BNE;
        end
        S_JMP: begin
          pc_write = 1'b1;
          pc_src = opcode == OP_RTYPE ? 2'd3 : 2'd2;
          reg_write = opcode == OP_JAL;
          reg_dst = opcode == OP_JAL ? 2'd2 : 2'd0;
        end
        S_EXC: begin
          pc_write = 1'b1;
          pc_src = 2'd3;
        end
        default: ;
      endcase
  end
  assign alu_op = rst ? '0 : ALUOP_W'(dec_op);
  assign zero_ext = !rst && dec_zx;
  assign instret = rst ? '0 : cnt;
  assign halt = !rst && state == S_HALT;
  assign state_o = rst ? 4'd0 : state;
`ifdef MC_EXC_EN
  assign epc_write = !rst && state == S_EXC;
  assign cause_write = epc_write;
  assign cause_code = !epc_write ? 5'd0 : (opcode == OP_RTYPE && funct == FN_SYSCALL) ? CAUSE_SYS : CAUSE_RI;
  assign exc_vec = EXC_VEC;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven scoreboard bench for mc_control_fsm (CNT_W=4 so the counter wrap is reachable)
module tb_mc_control_fsm;
  import mc_pkg::*;
  typedef struct packed {
    logic pc_write, pc_write_cond, bne_sel;
    logic [1:0] pc_src;
    logic ir_write, iord, mem_req, mem_we, reg_write;
    logic [1:0] reg_dst;
    logic mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic zero_ext;
    logic [3:0] alu_op;
    logic halt;
  } ctl_t;
  typedef struct {
    int idx;
    logic rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic rdy;
    logic [3:0] st;
    ctl_t c;
    logic [3:0] cnt;
    logic [6:0] exc;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic pc_write, pc_write_cond, bne_sel, ir_write, iord, mem_req, mem_we, reg_write;
  logic mem_to_reg, alu_src_a, zero_ext, halt;
  logic [1:0] pc_src, reg_dst, alu_src_b;
  logic [3:0] alu_op, instret, state_o;
`ifdef MC_EXC_EN
  logic epc_write, cause_write;
  logic [4:0] cause_code;
  logic [31:0] exc_vec;
`endif
  ctl_t act;
  vec_t vq[$], sb[$];
  vec_t mv;
  int checks = 0, errors = 0;
  logic [3:0] ecnt = 4'd0;
  logic [5:0] cop = 6'd0, cfn = 6'd0;
  logic [6:0] cexc = 7'd0;
  logic nr = 1'b0;
  always #5 clk = ~clk;
  mc_control_fsm #(.ALUOP_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .bne_sel(bne_sel), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord), .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .zero_ext(zero_ext), .alu_op(alu_op), .instret(instret), .halt(halt), .state_o(state_o)
`ifdef MC_EXC_EN
    , .epc_write(epc_write), .cause_write(cause_write), .cause_code(cause_code), .exc_vec(exc_vec)
`endif
  );
  assign act = {pc_write, pc_write_cond, bne_sel, pc_src, ir_write, iord, mem_req, mem_we, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_op, halt};
  task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s vec %0d got %h want %h", n, i, a, e);
    end
  endtask
  task automatic put(input logic r, input logic rdy, input state_t st, input ctl_t c);
    vec_t v;
    v.idx = vq.size();
    v.rst = r;
    v.op = cop;
    v.fn = cfn;
    v.rdy = rdy;
    v.st = r ? S_FETCH : st;
    v.c = r ? '0 : c;
    v.cnt = r ? 4'd0 : ecnt;
    v.exc = r ? 7'd0 : cexc;
    if (r) ecnt = 4'd0;
    cexc = 7'd0;
    vq.push_back(v);
  endtask
  task automatic fetch(input int w);
    ctl_t c;
    for (int i = 0; i <= w; i++) begin
      c = '0;
      c.mem_req = 1'b1;
      c.alu_src_b = 2'd1;
      c.alu_op = ALU_ADD;
      c.ir_write = (i == w);
      c.pc_write = (i == w);
      put(1'b0, i == w, S_FETCH, c);
    end
    c = '0;
    c.alu_src_b = 2'd3;
    put(1'b0, nr, S_DECODE, c);
  endtask
  task automatic rtype(input logic [5:0] fn, input logic [3:0] aop);
    ctl_t c;
    cop = 6'h00;
    cfn = fn;
    fetch(0);
    c = '0;
    c.alu_src_a = 1'b1;
    c.alu_op = aop;
    put(1'b0, nr, S_EX_R, c);
    c = '0;
    c.reg_write = 1'b1;
    c.reg_dst = 2'd1;
    put(1'b0, nr, S_WB_ALU, c);
    ecnt++;
  endtask
  task automatic itype(input logic [5:0] op, input logic [3:0] aop, input logic zx);
    ctl_t c;
    cop = op;
    cfn = op ^ 6'h2a;
    fetch(0);
    c = '0;
    c.alu_src_a = 1'b1;
    c.alu_src_b = 2'd2;
    c.alu_op = aop;
    c.zero_ext = zx;
    put(1'b0, nr, S_EX_I, c);
    c = '0;
    c.reg_write = 1'b1;
    put(1'b0, nr, S_WB_ALU, c);
    ecnt++;
  endtask
  task automatic maddr(input logic [5:0] op, input int fw);
    ctl_t c;
    cop = op;
    cfn = 6'h11;
    fetch(fw);
    c = '0;
    c.alu_src_a = 1'b1;
    c.alu_src_b = 2'd2;
    put(1'b0, nr, S_MADDR, c);
  endtask
  task automatic lw(input int fw, input int mw);
    ctl_t c;
    maddr(6'h23, fw);
    for (int i = 0; i <= mw; i++) begin
      c = '0;
      c.mem_req = 1'b1;
      c.iord = 1'b1;
      put(1'b0, i == mw, S_MRD, c);
    end
    c = '0;
    c.reg_write = 1'b1;
    c.mem_to_reg = 1'b1;
    put(1'b0, nr, S_WB_MEM, c);
    ecnt++;
  endtask
  task automatic sw(input int fw, input int mw);
    ctl_t c;
    maddr(6'h2b, fw);
    for (int i = 0; i <= mw; i++) begin
      c = '0;
      c.mem_req = 1'b1;
      c.mem_we = 1'b1;
      c.iord = 1'b1;
      put(1'b0, i == mw, S_MWR, c);
    end
    ecnt++;
  endtask
  task automatic br(input logic [5:0] op);
    ctl_t c;
    cop = op;
    cfn = 6'h05;
    fetch(0);
    c = '0;
    c.alu_src_a = 1'b1;
    c.alu_op = ALU_SUB;
    c.pc_write_cond = 1'b1;
    c.pc_src = 2'd1;
    c.bne_sel = (op == 6'h05);
    put(1'b0, nr, S_BR, c);
    ecnt++;
  endtask
  task automatic jmp(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    cop = op;
    cfn = fn;
    fetch(0);
    c = '0;
    c.pc_write = 1'b1;
    c.pc_src = op == 6'h00 ? 2'd3 : 2'd2;
    if (op == 6'h03) begin
      c.reg_write = 1'b1;
      c.reg_dst = 2'd2;
    end
    put(1'b0, nr, S_JMP, c);
    ecnt++;
  endtask
  task automatic bad(input logic [5:0] op, input logic [5:0] fn);
    cop = op;
    cfn = fn;
    fetch(0);
`ifdef MC_EXC_EN
    begin
      ctl_t c;
      c = '0;
      c.pc_write = 1'b1;
      c.pc_src = 2'd3;
      cexc = {2'b11, 5'd10};
      put(1'b0, nr, S_EXC, c);
    end
`else
    ecnt++;
`endif
  endtask
  task automatic syscall_seq();
    ctl_t c;
    cop = 6'h00;
    cfn = 6'h0c;
    fetch(0);
    c = '0;
`ifdef MC_EXC_EN
    c.pc_write = 1'b1;
    c.pc_src = 2'd3;
    cexc = {2'b11, 5'd8};
    put(1'b0, 1'b0, S_EXC, c);
`else
    c.halt = 1'b1;
    for (int i = 0; i < 4; i++) put(1'b0, i[0], S_HALT, c);
`endif
    put(1'b1, 1'b1, S_FETCH, '0);
  endtask
  task automatic build();
    ctl_t c;
    put(1'b1, 1'b0, S_FETCH, '0);
    put(1'b1, 1'b1, S_FETCH, '0);
    rtype(6'h20, ALU_ADD);
    lw(0, 3);
    sw(1, 0);
    nr = 1'b1;
    br(6'h05);
    jmp(6'h03, 6'h00);
    nr = 1'b0;
    jmp(6'h00, 6'h08);
    jmp(6'h02, 6'h00);
    br(6'h04);
    itype(6'h0c, ALU_AND, 1'b1);
    itype(6'h0a, ALU_SLT, 1'b0);
    itype(6'h0e, ALU_XOR, 1'b1);
    itype(6'h09, ALU_ADD, 1'b0);
    rtype(6'h22, ALU_SUB);
    rtype(6'h00, ALU_SLL);
    rtype(6'h03, ALU_SRA);
    rtype(6'h27, ALU_NOR);
    rtype(6'h2a, ALU_SLT);
    bad(6'h3f, 6'h00);
    bad(6'h00, 6'h3f);
    maddr(6'h23, 0);
    c = '0;
    c.mem_req = 1'b1;
    c.iord = 1'b1;
    put(1'b0, 1'b0, S_MRD, c);
    put(1'b0, 1'b0, S_MRD, c);
    put(1'b1, 1'b0, S_FETCH, '0);
    put(1'b1, 1'b0, S_FETCH, '0);
    for (int i = 0; i < 16; i++) jmp(6'h02, 6'h00);
    rtype(6'h25, ALU_OR);
    syscall_seq();
    rtype(6'h20, ALU_ADD);
  endtask
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mv = sb.pop_front();
      chk("state", mv.idx, 32'(state_o), 32'(mv.st));
      chk("ctl", mv.idx, 32'(act), 32'(mv.c));
      chk("instret", mv.idx, 32'(instret), 32'(mv.cnt));
`ifdef MC_EXC_EN
      chk("exc", mv.idx, 32'({epc_write, cause_write, cause_code}), 32'(mv.exc));
`endif
    end
  end
  initial begin
    build();
    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      opcode = vq[i].op;
      funct = vq[i].fn;
      mem_ready = vq[i].rdy;
      sb.push_back(vq[i]);
    end
    @(negedge clk);
    #4;
    chk("drain", vq.size(), 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
